// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice scheduler. Takes a single note-on/note-off
//                event stream and assigns each note to one of NUM_OSCILLATORS
//                oscillator voices. It drives each voice's active flag and
//                playback rate, plus a one-cycle restart pulse per voice.
//
//  Ports       : clk_in        - system clock
//                rst_in        - synchronous active-high reset
//                valid_in      - one-cycle event strobe
//                is_note_on_in - 1 = note-on, 0 = note-off (when valid_in)
//                rate_in       - playback rate / note key (when valid_in)
//                clear_all_in  - all-notes-off pulse
//                is_on_out     - per-voice active flag
//                rates_out     - packed per-voice rate, voice i at
//                                [i*RATE_WIDTH +: RATE_WIDTH]
//                restart_out   - per-voice restart pulse
//                full_out      - all voices active
//                drop_out      - pulse: a note-on was discarded
//
//  Build option: VOICE_STEAL_EN - when defined, a note-on with every voice
//                busy steals the oldest voice (largest age, lowest index on
//                a tie). When undefined, that note-on is dropped.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int RATE_WIDTH      = 24,
    parameter int AGE_WIDTH       = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  valid_in,
    input  logic                                  is_note_on_in,
    input  logic [RATE_WIDTH-1:0]                 rate_in,
    input  logic                                  clear_all_in,
    output logic [NUM_OSCILLATORS-1:0]            is_on_out,
    output logic [NUM_OSCILLATORS*RATE_WIDTH-1:0] rates_out,
    output logic [NUM_OSCILLATORS-1:0]            restart_out,
    output logic                                  full_out,
    output logic                                  drop_out
);

    localparam logic [AGE_WIDTH-1:0] c_AGE_MAX = '1;

    logic [NUM_OSCILLATORS-1:0] r_is_on;
    logic [NUM_OSCILLATORS-1:0] w_is_on_nxt;
    logic [RATE_WIDTH-1:0]      r_rate     [NUM_OSCILLATORS];
    logic [RATE_WIDTH-1:0]      w_rate_nxt [NUM_OSCILLATORS];
    logic [AGE_WIDTH-1:0]       r_age      [NUM_OSCILLATORS];
    logic [AGE_WIDTH-1:0]       w_age_nxt  [NUM_OSCILLATORS];
    logic [NUM_OSCILLATORS-1:0] r_restart;
    logic [NUM_OSCILLATORS-1:0] w_restart_nxt;
    logic                       r_full;
    logic                       r_drop;
    logic                       w_drop_nxt;

    // One-hot search results over registered state
    logic [NUM_OSCILLATORS-1:0] w_match_oh;
    logic [NUM_OSCILLATORS-1:0] w_free_oh;
    logic [NUM_OSCILLATORS-1:0] w_tgt_oh;
`ifdef VOICE_STEAL_EN
    logic [NUM_OSCILLATORS-1:0] w_oldest_oh;
    logic [AGE_WIDTH-1:0]       w_best_age;
`endif

    // Lowest-index matching active voice and lowest-index free voice.
    // Scanning from the top down lets the last hit (lowest index) win.
    always_comb begin
        w_match_oh = '0;
        w_free_oh  = '0;
        for (int i = NUM_OSCILLATORS - 1; i >= 0; i--) begin
            if (r_is_on[i] && (r_rate[i] == rate_in)) begin
                w_match_oh    = '0;
                w_match_oh[i] = 1'b1;
            end
            if (!r_is_on[i]) begin
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Oldest voice; strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_oldest_oh    = '0;
        w_oldest_oh[0] = 1'b1;
        w_best_age     = r_age[0];
        for (int i = 1; i < NUM_OSCILLATORS; i++) begin
            if (r_age[i] > w_best_age) begin
                w_oldest_oh    = '0;
                w_oldest_oh[i] = 1'b1;
                w_best_age     = r_age[i];
            end
        end
    end
`endif

    always_comb begin
        w_is_on_nxt   = r_is_on;
        w_rate_nxt    = r_rate;
        w_age_nxt     = r_age;
        w_restart_nxt = '0;
        w_drop_nxt    = 1'b0;
        w_tgt_oh      = '0;

        if (clear_all_in) begin
            // Rates are retained so free voices never glitch to 0
            w_is_on_nxt = '0;
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                w_age_nxt[i] = '0;
            end
        end else if (valid_in) begin
            if (is_note_on_in) begin
                if (rate_in == '0) begin
                    w_drop_nxt = 1'b1;
                end else if (|w_match_oh) begin
                    w_tgt_oh = w_match_oh;
                end else if (|w_free_oh) begin
                    w_tgt_oh = w_free_oh;
                end else begin
`ifdef VOICE_STEAL_EN
                    w_tgt_oh = w_oldest_oh;
`else
                    w_drop_nxt = 1'b1;
`endif
                end

                // Target voice is (re)started; every other active voice ages
                for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                    if (w_tgt_oh[i]) begin
                        w_is_on_nxt[i]   = 1'b1;
                        w_rate_nxt[i]    = rate_in;
                        w_age_nxt[i]     = '0;
                        w_restart_nxt[i] = 1'b1;
                    end else if ((|w_tgt_oh) && r_is_on[i] && (r_age[i] != c_AGE_MAX)) begin
                        w_age_nxt[i] = r_age[i] + 1'b1;
                    end
                end
            end else if (rate_in != '0) begin
                for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                    if (r_is_on[i] && (r_rate[i] == rate_in)) begin
                        w_is_on_nxt[i] = 1'b0;
                        w_age_nxt[i]   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_is_on   <= '0;
            r_restart <= '0;
            r_full    <= 1'b0;
            r_drop    <= 1'b0;
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                r_rate[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_is_on   <= w_is_on_nxt;
            r_restart <= w_restart_nxt;
            r_full    <= &w_is_on_nxt;
            r_drop    <= w_drop_nxt;
            r_rate    <= w_rate_nxt;
            r_age     <= w_age_nxt;
        end
    end

    assign is_on_out   = r_is_on;
    assign restart_out = r_restart;
    assign full_out    = r_full;
    assign drop_out    = r_drop;

    generate
        for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_pack
            assign rates_out[g*RATE_WIDTH +: RATE_WIDTH] = r_rate[g];
        end
    endgenerate

endmodule
`default_nettype wire
